// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared N64 controller constants, wire patterns and FSM encoding
package n64_pkg;

    // Quarter patterns indexed by quarter number (bit 0 = q0)
    localparam logic [3:0] PAT_ZERO = 4'b1000;
    localparam logic [3:0] PAT_ONE  = 4'b1110;
    localparam logic [2:0] PAT_STOP = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BIT  = 2'd2,
        ST_STOP = 2'd3
    } tx_state_t;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam int INFO_BYTES   = 3;
    localparam int STATUS_BYTES = 4;
    localparam int READ_BYTES   = 33;

endpackage

// File: rtl/n64_response_tx_quarter_timer.sv
// rtl/n64_response_tx_quarter_timer.sv - quarter-bit tick counter and quarter index
module n64_response_tx_quarter_timer #(
    parameter int QUARTER_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_run,
    output logic       o_quarter_end,
    output logic       o_first_tick,
    output logic [1:0] o_quarter
);
    localparam int TW = (QUARTER_TICKS > 1) ? $clog2(QUARTER_TICKS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(QUARTER_TICKS - 1);

    logic [TW-1:0] r_tick;
    logic [1:0]    r_quarter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick    <= '0;
            r_quarter <= 2'd0;
        end else if (i_clear) begin
            r_tick    <= '0;
            r_quarter <= 2'd0;
        end else if (i_run) begin
            if (r_tick == LAST_TICK) begin
                r_tick    <= '0;
                r_quarter <= r_quarter + 2'd1;
            end else begin
                r_tick <= r_tick + TW'(1);
            end
        end
    end

    assign o_quarter_end = (r_tick == LAST_TICK);
    assign o_first_tick  = (r_tick == '0);
    assign o_quarter     = r_quarter;

endmodule

// File: rtl/n64_response_tx.sv
// rtl/n64_response_tx.sv - serializes controller reply bytes onto the N64 one-wire line
module n64_response_tx
    import n64_pkg::*;
#(
    parameter int QUARTER_TICKS = 4,
    parameter int NUM_BYTES_W   = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [NUM_BYTES_W-1:0] num_bytes,
    input  logic [7:0]             byte_data,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   data_tx,
    output logic                   data_oe,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun
);
    tx_state_t              r_state, w_next;
    logic [7:0]             r_shift, r_hold;
    logic                   r_hold_valid;
    logic [2:0]             r_bit;
    logic [NUM_BYTES_W-1:0] r_num, r_bytes_left;
    logic                   r_done;

    logic       w_quarter_end, w_first_tick, w_timer_clear, w_bit_end, w_prefetch;
    logic [1:0] w_quarter;

    assign w_timer_clear = (r_state != ST_BIT) && (r_state != ST_STOP);
    assign w_bit_end     = w_quarter_end && (w_quarter == 2'd3);
    // Next byte is requested exactly once, at the very first cycle of bit 0
    assign w_prefetch    = (r_state == ST_BIT) && (r_bit == 3'd0) && (w_quarter == 2'd0)
                           && w_first_tick && (r_bytes_left != '0);

    n64_response_tx_quarter_timer #(.QUARTER_TICKS(QUARTER_TICKS)) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clear       (w_timer_clear),
        .i_run         (!w_timer_clear),
        .o_quarter_end (w_quarter_end),
        .o_first_tick  (w_first_tick),
        .o_quarter     (w_quarter)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= 8'd0;
            r_hold       <= 8'd0;
            r_hold_valid <= 1'b0;
            r_bit        <= 3'd0;
            r_num        <= '0;
            r_bytes_left <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_STOP) && (w_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_hold_valid <= 1'b0;
                    if (start && (num_bytes != '0)) r_num <= num_bytes;
                end
                ST_LOAD: begin
                    if (byte_valid) begin
                        r_shift      <= byte_data;
                        r_bytes_left <= r_num - NUM_BYTES_W'(1);
                        r_bit        <= 3'd7;
                    end
                end
                ST_BIT: begin
                    if (w_prefetch && byte_valid) begin
                        r_hold       <= byte_data;
                        r_hold_valid <= 1'b1;
                        r_bytes_left <= r_bytes_left - NUM_BYTES_W'(1);
                    end
                    if (w_bit_end) begin
                        if (r_bit != 3'd0) begin
                            r_bit <= r_bit - 3'd1;
                        end else if (r_hold_valid) begin
                            r_shift      <= r_hold;
                            r_hold_valid <= 1'b0;
                            r_bit        <= 3'd7;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        data_oe    = 1'b0;
        data_tx    = 1'b1;
        underrun   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (num_bytes != '0)) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid) w_next = ST_BIT;
            end
            ST_BIT: begin
                data_oe    = 1'b1;
                data_tx    = r_shift[r_bit] ? PAT_ONE[w_quarter] : PAT_ZERO[w_quarter];
                byte_ready = w_prefetch;
                underrun   = w_prefetch && !byte_valid;
                if (w_bit_end && (r_bit == 3'd0) && !r_hold_valid) w_next = ST_STOP;
            end
            ST_STOP: begin
                data_oe = 1'b1;
                data_tx = PAT_STOP[w_quarter];
                if (w_quarter_end && (w_quarter == 2'd2)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_n64_response_tx.sv
// tb/tb_n64_response_tx.sv - self-checking bench for n64_response_tx
module tb_n64_response_tx;
    localparam int Q   = 2;
    localparam int NBW = 6;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [NBW-1:0] num_bytes = '0;
    logic [7:0]     byte_data = 8'd0;
    logic           byte_valid = 1'b0;
    logic           byte_ready, data_tx, data_oe, busy, done, underrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] tx_bytes[$];
    logic       exp_wave[$];

    always #5 clk = ~clk;

    n64_response_tx #(.QUARTER_TICKS(Q), .NUM_BYTES_W(NBW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_bytes  (num_bytes),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .data_tx    (data_tx),
        .data_oe    (data_oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Reference line: each bit is L for Q, value for 2Q, H for Q; stop is L 2Q, H Q
    task automatic build_expected(input int nsent);
        exp_wave.delete();
        for (int b = 0; b < nsent; b++) begin
            for (int k = 7; k >= 0; k--) begin
                logic v;
                v = tx_bytes[b][k];
                repeat (Q)     exp_wave.push_back(1'b0);
                repeat (2 * Q) exp_wave.push_back(v);
                repeat (Q)     exp_wave.push_back(1'b1);
            end
        end
        repeat (2 * Q) exp_wave.push_back(1'b0);
        repeat (Q)     exp_wave.push_back(1'b1);
    endtask

    task automatic fill_random(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
    endtask

    // Starts a reply at the current negedge and supplies bytes on byte_ready.
    // miss_idx: handshake number (2..n) whose byte is withheld, 0 = none.
    task automatic run_reply(input string name, input int n, input int miss_idx,
                             input int load_delay, input int busy_start_at);
        int cyc, t_load, done_cyc, hs, ready_cycles, und_cnt, load_wait, nsent, bad, busy_bad, exp_ready;
        logic oe_q[$];
        logic tx_q[$];
        logic exp_oe;
        t_load = -1; done_cyc = -1; hs = 0; ready_cycles = 0; und_cnt = 0;
        load_wait = 0; busy_bad = 0; cyc = 0;
        num_bytes = NBW'(n); start = 1'b1; byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 3000 && done_cyc < 0) begin
            oe_q.push_back(data_oe);
            tx_q.push_back(data_tx);
            if (done) done_cyc = cyc;
            else if (!busy) busy_bad++;
            byte_valid = 1'b0;
            if (byte_ready) begin
                ready_cycles++;
                if (t_load < 0) begin
                    if (load_wait < load_delay) begin
                        load_wait++;
                        if (data_oe) busy_bad++;
                    end else begin
                        byte_valid = 1'b1; byte_data = tx_bytes[0]; t_load = cyc; hs = 1;
                    end
                end else begin
                    if (hs + 1 != miss_idx) begin
                        byte_valid = 1'b1; byte_data = tx_bytes[hs];
                    end
                    hs++;
                end
            end
            start = (cyc == busy_start_at);
            if (start) num_bytes = NBW'(7);
            #1;
            if (underrun) und_cnt++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; byte_valid = 1'b0;

        nsent = (miss_idx == 0) ? n : miss_idx - 1;
        build_expected(nsent);
        exp_ready = load_delay + 1 + ((miss_idx == 0) ? n - 1 : miss_idx - 1);

        checks++;
        if (done_cyc !== t_load + 1 + exp_wave.size()) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, t_load + 1 + exp_wave.size());
        end
        bad = 0;
        for (int i = 0; i < oe_q.size(); i++) begin
            exp_oe = (t_load >= 0) && (i > t_load) && (i <= t_load + exp_wave.size());
            if (oe_q[i] !== exp_oe) bad++;
            else if (exp_oe && tx_q[i] !== exp_wave[i - t_load - 1]) bad++;
        end
        checks++;
        if (bad != 0 || t_load < 0) begin
            errors++;
            $display("FAIL %s waveform: got %0d bad cycles (load at %0d) want 0", name, bad, t_load);
        end
        checks++;
        if (ready_cycles != exp_ready) begin
            errors++;
            $display("FAIL %s ready_cycles: got %0d want %0d", name, ready_cycles, exp_ready);
        end
        checks++;
        if (und_cnt != ((miss_idx == 0) ? 0 : 1)) begin
            errors++;
            $display("FAIL %s underrun_pulses: got %0d want %0d", name, und_cnt, (miss_idx == 0) ? 0 : 1);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_or_load_line: got %0d bad cycles want 0", name, busy_bad);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_oe !== 1'b0 || data_tx !== 1'b1) begin
            errors++;
            $display("FAIL %s after_done: got busy=%b done=%b oe=%b tx=%b want 0 0 0 1",
                     name, busy, done, data_oe, data_tx);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (data_oe !== 1'b0 || data_tx !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got oe=%b tx=%b rdy=%b busy=%b done=%b und=%b want 0 1 0 0 0 0",
                     data_oe, data_tx, byte_ready, busy, done, underrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        tx_bytes = '{8'hA5};
        run_reply("single_a5", 1, 0, 0, -1);
    endtask

    task automatic test_info_reply();
        tx_bytes = '{8'h05, 8'h00, 8'h02};
        run_reply("info", 3, 0, 0, -1);
    endtask

    task automatic test_underrun();
        fill_random(4);
        run_reply("status_underrun", 4, 2, 0, -1);
    endtask

    task automatic test_load_wait();
        fill_random(2);
        run_reply("load_wait", 2, 0, 50, -1);
    endtask

    task automatic test_ignored_start();
        int bad;
        bad = 0;
        num_bytes = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            if (busy || byte_ready || data_oe || done) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_length_start: got %0d active cycles want 0", bad);
        end
        fill_random(2);
        run_reply("start_while_busy", 2, 0, 0, 40);
    endtask

    task automatic test_reset_mid();
        int oe_cycles, cyc, bad;
        logic was_oe;
        oe_cycles = 0; cyc = 0; bad = 0;
        num_bytes = NBW'(3); start = 1'b1; byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h5A;
        while (oe_cycles < 32 * Q + 5 && cyc < 500) begin
            if (data_oe) oe_cycles++;
            @(negedge clk);
            cyc++;
        end
        was_oe = data_oe;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (was_oe !== 1'b1 || data_oe !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: got was_oe=%b oe=%b busy=%b rdy=%b want 1 0 0 0",
                     was_oe, data_oe, busy, byte_ready);
        end
        repeat (3) begin
            @(negedge clk);
            if (done || busy || data_oe || underrun) bad++;
        end
        reset_n = 1'b1; byte_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || data_oe || underrun) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", bad);
        end
        fill_random(2);
        run_reply("after_reset", 2, 0, 0, -1);
    endtask

    task automatic test_random();
        int n, miss, dly;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 4);
            miss = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(2, n) : 0;
            dly = $urandom_range(0, 6);
            fill_random(n);
            run_reply($sformatf("random%0d_n%0d_m%0d", k, n, miss), n, miss, dly, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_info_reply();
        test_underrun();
        test_reset_mid();
        test_ignored_start();
        test_load_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/n64_response_tx.md
Name: n64_response_tx

Overview:
- Downstream transmit stage for the fake N64 controller.
- The command decoder decides that a reply is due (info/reset, button status, or read data). This block serializes the reply bytes onto the one-wire data line using N64 wire encoding, then appends the controller stop bit and releases the line.
- Byte content comes from the controller FSM over a valid/ready handshake.
- The block drives a tri-state pair: data_tx is the value and data_oe is the enable. A top-level pad performs the actual z.

Parameters:
- QUARTER_TICKS, 4, clk cycles per quarter bit period (N64 bit = 4 quarters, 1 us each; 4 suits a 4 MHz clk); must be >= 1.
- NUM_BYTES_W, 6, width of num_bytes; covers the 33-byte read reply.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a reply; honoured only when idle.
- num_bytes  in  NUM_BYTES_W  number of bytes in the reply; sampled when start is accepted.
- byte_data  in  8  next reply byte, sent MSB first.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  block takes byte_data this cycle if byte_valid is high.
- data_tx  out  1  line value while data_oe = 1.
- data_oe  out  1  1 = drive data_tx, 0 = release (pull-up holds the line high).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the line is released after the stop bit.
- underrun  out  1  one-cycle pulse when the next byte was not available in time.

Behaviour:
- Reset (async, immediate): data_oe=0, data_tx=1, byte_ready=0, busy=0, done=0, underrun=0, FSM=IDLE, all counters cleared.
  - Reset during a transmission aborts it at once. No done or underrun pulse is produced.
- Wire encoding, quarters q0..q3:
  - logic 0 = L L L H
  - logic 1 = L H H H
  - controller stop = L L H, then released in q3 (data_oe=0)
- FSM states: IDLE, LOAD, BIT, STOP.
- IDLE:
  - start=1 and num_bytes != 0 → LOAD; busy=1 from the next cycle.
  - start with num_bytes=0 is ignored.
  - start is ignored in every state other than IDLE.
- LOAD (first byte only):
  - byte_ready=1 and the line stays released.
  - Waits indefinitely for byte_valid.
  - On handshake at cycle T: shift register ← byte_data, bytes_left ← num_bytes-1, → BIT.
  - Cycle T+1: data_oe=1, data_tx=0 (q0 of bit 7).
- BIT:
  - Quarter counter runs 0..QUARTER_TICKS-1; quarter index runs 0..3; bit index runs 7..0.
  - Each bit occupies exactly 4*QUARTER_TICKS cycles, back-to-back with no gaps, including across byte boundaries.
- Next-byte prefetch (when bytes_left > 0):
  - byte_ready=1 for exactly one cycle: the first cycle of bit 0, q0, of the current byte.
  - If byte_valid is high then, the byte goes into a holding register and bytes_left decrements.
  - If byte_valid is low then, underrun pulses that cycle. The current byte still completes, then the block goes to STOP (truncated reply).
- After bit 0 completes:
  - If a held byte is present: load it and continue in BIT.
  - Otherwise: → STOP.
- STOP:
  - Drive L for 2*QUARTER_TICKS cycles, then H for QUARTER_TICKS cycles.
  - Then data_oe=0, done=1 for one cycle, busy=0, → IDLE.
- Latency for an N-byte reply without underrun: data_oe is high for (32*N + 3)*QUARTER_TICKS cycles starting at T+1; done is asserted in the first cycle after that window.
- byte_ready is never high in IDLE, STOP, or BIT outside the prefetch cycle.
- data_tx when data_oe=0: don't-care, but held at 1.

Decomposition:
- Shared package n64_pkg:
  - quarter-pattern constants for logic 0, logic 1, and controller stop
  - FSM state encodings
  - command codes (0x00 info, 0x01 status, 0x02 read, 0x03 write, 0xFF reset)
  - reply lengths (INFO_BYTES=3, STATUS_BYTES=4, READ_BYTES=33)
- One sub-module is natural: quarter_timer.
  - Counts 0..QUARTER_TICKS-1 and emits quarter_end.
  - Tracks the quarter index 0..3.
  - Clear input is used on load.

Test Plan:
- QUARTER_TICKS=2, num_bytes=1, byte 0xA5 valid at LOAD:
  - Line reads 1,0,1,0,0,1,0,1 as L2/H6 (logic 1) and L6/H2 (logic 0) slices.
  - Stop bit L4 H2, then data_oe=0.
  - done at T+1+70; busy low after.
- Info reply, num_bytes=3, bytes 0x05,0x00,0x02 supplied immediately on every byte_ready:
  - No gaps at byte boundaries.
  - byte_ready high exactly 3 cycles total.
  - data_oe window = 99*Q cycles; underrun never pulses.
- Status reply of 4 bytes with byte_valid low at the 2nd byte's prefetch cycle:
  - underrun pulses once.
  - Byte 1 completes, then the stop bit is sent; data_oe window = 35*Q; done pulses.
- Assert reset_n=0 mid-bit of byte 2:
  - data_oe drops the same cycle with no clock needed; busy=0; no done.
  - After release, a new start sends a correct reply.
- start pulsed while busy, plus start with num_bytes=0 in IDLE:
  - Both are ignored: no extra byte_ready, and the waveform is unchanged.
- LOAD with byte_valid withheld for 50 cycles:
  - Line stays released and busy=1.
  - Transmission begins the cycle after the handshake.
